// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//    Shares one external combinational ALU between NREQ requesters. The
//    requesters are granted round-robin. The granted operation drives the
//    ALU, and its result and compare flags are captured in one response
//    register, which is returned to the requester that owns it. A requester
//    can hold req_lock to keep the ALU across back-to-back operations.
//
//    Optional feature (macro ALU_ARB_PERF_EN): adds the free-running
//    perf_grants and perf_stalls counters.
//
// Ports
//    clk, rst_n          clock, async active-low reset
//    req_valid/ready     per-requester operation handshake
//    req_lock            keep ownership after this operation
//    req_opc/imm/cond    packed per-requester opcode fields (slice i)
//    req_op1/op2         packed per-requester operands (slice i)
//    alu_*               to/from the shared combinational ALU
//    rsp_valid/ready     one-hot response handshake
//    rsp_res/cmp         registered result and compare flags
//    busy                response register occupied or lock held
//    perf_grants/stalls  (ALU_ARB_PERF_EN only) handshake / stall counters
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_OPEN   | round-robin among all valid requesters
// ST_LOCKED | only the lock owner may be granted; rr frozen until release
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ-1:0]     req_lock,
   input  logic [6*NREQ-1:0]   req_opc,
   input  logic [NREQ-1:0]     req_imm,
   input  logic [NREQ-1:0]     req_cond,
   input  logic [32*NREQ-1:0]  req_op1,
   input  logic [32*NREQ-1:0]  req_op2,
   output logic [5:0]          alu_opc,
   output logic                alu_imm,
   output logic                alu_cond,
   output logic [31:0]         alu_op1,
   output logic [31:0]         alu_op2,
   input  logic [31:0]         alu_res,
   input  logic [1:0]          alu_cmp,
   output logic [NREQ-1:0]     rsp_valid,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [31:0]         rsp_res,
   output logic [1:0]          rsp_cmp,
   output logic                busy
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [31:0]         perf_grants,
   output logic [31:0]         perf_stalls
`endif
);

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t          state;
   logic [IDW-1:0]  rr;
   logic [IDW-1:0]  owner;

   logic [5:0]      opc_arr [NREQ];
   logic [31:0]     op1_arr [NREQ];
   logic [31:0]     op2_arr [NREQ];

   logic            slot_free;
   logic            rr_found;
   logic [IDW-1:0]  rr_pick;
   logic [IDW-1:0]  scan_idx;
   logic            cand_valid;
   logic [IDW-1:0]  cand_idx;
   logic            grant;
   logic [IDW-1:0]  sel;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign opc_arr[g] = req_opc[6*g +: 6];
      assign op1_arr[g] = req_op1[32*g +: 32];
      assign op2_arr[g] = req_op2[32*g +: 32];
   end

   function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
      if (int'(i) == NREQ - 1) return '0;
      return i + 1'b1;
   endfunction

   // Draining and refilling the response register in the same cycle is allowed.
   assign slot_free = (rsp_valid == '0) || ((rsp_valid & rsp_ready) != '0);

   // First valid requester at or after rr, with wrap-around.
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = '0;
      scan_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = IDW'((int'(rr) + k) % NREQ);
         if (!rr_found && req_valid[scan_idx]) begin
            rr_found = 1'b1;
            rr_pick  = scan_idx;
         end
      end
   end

   always_comb begin
      if (state == ST_LOCKED) begin
         cand_valid = req_valid[owner];
         cand_idx   = owner;
      end else begin
         cand_valid = rr_found;
         cand_idx   = rr_pick;
      end
   end

   // rst_n gating keeps req_ready low for the whole time reset is asserted.
   assign grant = rst_n && slot_free && cand_valid;

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[cand_idx] = 1'b1;
   end

   // Idle cycles park the mux on rr so the ALU inputs don't toggle needlessly.
   assign sel      = grant ? cand_idx : rr;
   assign alu_opc  = opc_arr[sel];
   assign alu_imm  = req_imm[sel];
   assign alu_cond = req_cond[sel];
   assign alu_op1  = op1_arr[sel];
   assign alu_op2  = op2_arr[sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_OPEN;
         rr        <= '0;
         owner     <= '0;
         rsp_valid <= '0;
         rsp_res   <= '0;
         rsp_cmp   <= '0;
      end else begin
         if (grant) begin
            rsp_valid <= req_ready;
            rsp_res   <= alu_res;
            rsp_cmp   <= alu_cmp;
            if (state == ST_OPEN) begin
               rr <= next_idx(cand_idx);
               if (req_lock[cand_idx]) begin
                  state <= ST_LOCKED;
                  owner <= cand_idx;
               end
            end else if (!req_lock[cand_idx]) begin
               state <= ST_OPEN;
               rr    <= next_idx(owner);
            end
         end else if ((rsp_valid & rsp_ready) != '0) begin
            rsp_valid <= '0;
         end
      end
   end

   assign busy = (rsp_valid != '0) || (state == ST_LOCKED);

`ifdef ALU_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_grants <= '0;
         perf_stalls <= '0;
      end else begin
         if (grant) perf_grants <= perf_grants + 32'd1;
         if ((req_valid != '0) && !grant) perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//    Self-checking bench for alu_arbiter (NREQ=2). A small ALU is modelled
//    behind the DUT's alu_* ports. A reference model built on integers
//    (owner index, rr, lock owner) predicts every output once per cycle.
//    Directed scenarios add literal expectations, followed by a
//    randomized run.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
   localparam int N = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid, req_ready, req_lock, req_imm, req_cond;
   logic [N-1:0]      rsp_valid, rsp_ready;
   logic [6*N-1:0]    req_opc;
   logic [32*N-1:0]   req_op1, req_op2;
   logic [5:0]        alu_opc;
   logic              alu_imm, alu_cond;
   logic [31:0]       alu_op1, alu_op2, alu_res, rsp_res;
   logic [1:0]        alu_cmp, rsp_cmp;
   logic              busy;
`ifdef ALU_ARB_PERF_EN
   logic [31:0]       perf_grants, perf_stalls;
`endif

   alu_arbiter #(.NREQ(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
      .req_opc(req_opc), .req_imm(req_imm), .req_cond(req_cond),
      .req_op1(req_op1), .req_op2(req_op2),
      .alu_opc(alu_opc), .alu_imm(alu_imm), .alu_cond(alu_cond),
      .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_res(alu_res), .alu_cmp(alu_cmp),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_res(rsp_res), .rsp_cmp(rsp_cmp), .busy(busy)
`ifdef ALU_ARB_PERF_EN
      , .perf_grants(perf_grants), .perf_stalls(perf_stalls)
`endif
   );

   always #5 clk = ~clk;

   // Toy ALU: returns {cmp[1]=LT, cmp[0]=EQ, result}.
   function automatic logic [33:0] alu_fn(input logic [5:0] opc, input logic imm,
                                          input logic cond, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [31:0] bb;
      logic [31:0] r;
      bb = imm ? {16'h0, b[15:0]} : b;
      case (opc[2:0])
         3'd0:    r = a + bb;
         3'd1:    r = a - bb;
         3'd2:    r = a & bb;
         3'd3:    r = a | bb;
         3'd4:    r = a ^ bb;
         3'd5:    r = cond ? a : bb;
         default: r = a << bb[4:0];
      endcase
      return {(a < bb), (a == bb), r};
   endfunction

   always_comb {alu_cmp, alu_res} = alu_fn(alu_opc, alu_imm, alu_cond, alu_op1, alu_op2);

   int          n_checks = 0;
   int          n_fail   = 0;

   int          m_rr, m_owner, m_rsp;
   bit          m_locked;
   logic [31:0] m_res;
   logic [1:0]  m_cmp;
   logic [31:0] m_grants, m_stalls;
   int          g_idx;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rr = 0; m_owner = 0; m_rsp = -1; m_locked = 0;
      m_res = '0; m_cmp = '0; m_grants = '0; m_stalls = '0;
   endtask

   // One cycle of the reference model: check at the falling edge, then
   // advance the model to the state after the next rising edge.
   task automatic step();
      int          cand;
      int          s;
      bit          free;
      bit          grant;
      logic [N-1:0] exp_rdy;
      logic [N-1:0] exp_rv;
      @(negedge clk);
      free = (m_rsp < 0) ? 1'b1 : rsp_ready[m_rsp];
      cand = -1;
      if (m_locked) begin
         if (req_valid[m_owner]) cand = m_owner;
      end else begin
         for (int k = 0; k < N; k++)
            if (cand < 0 && req_valid[(m_rr + k) % N]) cand = (m_rr + k) % N;
      end
      grant = free && (cand >= 0);
      exp_rdy = '0;
      if (grant) exp_rdy[cand] = 1'b1;
      exp_rv = '0;
      if (m_rsp >= 0) exp_rv[m_rsp] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_res", rsp_res, m_res);
      chk("rsp_cmp", rsp_cmp, m_cmp);
      chk("busy", busy, (m_rsp >= 0) || m_locked);
      s = grant ? cand : m_rr;
      chk("alu_opc", alu_opc, req_opc[6*s +: 6]);
      chk("alu_op1", alu_op1, req_op1[32*s +: 32]);
      chk("alu_op2", alu_op2, req_op2[32*s +: 32]);
      chk("alu_imm", alu_imm, req_imm[s]);
      chk("alu_cond", alu_cond, req_cond[s]);
`ifdef ALU_ARB_PERF_EN
      chk("perf_grants", perf_grants, m_grants);
      chk("perf_stalls", perf_stalls, m_stalls);
`endif
      g_idx = grant ? cand : -1;
      if (grant) begin
         m_grants++;
         m_rsp = cand;
         {m_cmp, m_res} = alu_fn(req_opc[6*cand +: 6], req_imm[cand], req_cond[cand],
                                 req_op1[32*cand +: 32], req_op2[32*cand +: 32]);
         if (!m_locked) begin
            m_rr = (cand + 1) % N;
            if (req_lock[cand]) begin
               m_locked = 1;
               m_owner  = cand;
            end
         end else if (!req_lock[cand]) begin
            m_locked = 0;
            m_rr     = (m_owner + 1) % N;
         end
      end else if (m_rsp >= 0 && rsp_ready[m_rsp]) begin
         m_rsp = -1;
      end
      if (req_valid != '0 && !grant) m_stalls++;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rand();
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = ($urandom_range(0, 9) < 7);
         req_lock[i]        = ($urandom_range(0, 3) == 0);
         req_imm[i]         = 1'($urandom);
         req_cond[i]        = 1'($urandom);
         req_opc[6*i +: 6]  = 6'($urandom);
         req_op1[32*i +: 32] = $urandom;
         req_op2[32*i +: 32] = ($urandom_range(0, 7) == 0) ? req_op1[32*i +: 32] : $urandom;
         rsp_ready[i]       = ($urandom_range(0, 3) != 0);
      end
   endtask

   logic [1:0] exp_alt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      rst_n = 1'b0;
      model_reset();
      drive_rand();
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      #2;
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_res", rsp_res, 32'd0);
      req_valid = 2'b00;
      #10 rst_n = 1'b1;
      adv();

      // Both valid, responses consumed at once: strict alternation.
      for (int k = 0; k < 4; k++) begin
         drive_rand();
         req_valid = 2'b11; req_lock = 2'b00; rsp_ready = 2'b11;
         step();
         chk("alt_grant", req_ready, exp_alt[k]);
         if (k > 0) chk("alt_rsp", rsp_valid, exp_alt[k-1]);
         adv();
      end

      // Single requester, 5 + 3.
      drive_rand();
      req_valid = 2'b01; req_lock = 2'b00; rsp_ready = 2'b11;
      req_opc[5:0] = 6'd0; req_imm[0] = 1'b0;
      req_op1[31:0] = 32'd5; req_op2[31:0] = 32'd3;
      step();
      chk("add_ready", req_ready, 2'b01);
`ifdef ALU_ARB_PERF_EN
      chk("perf_g4", perf_grants, 32'd4);
`endif
      adv();
      req_valid = 2'b00;
      step();
      chk("add_rsp_valid", rsp_valid, 2'b01);
      chk("add_rsp_res", rsp_res, 32'd8);
      chk("add_rsp_cmp", rsp_cmp, 2'b00);
      adv();

      // Occupied slot blocks a new grant until the drain cycle.
      drive_rand();
      req_valid = 2'b01; req_lock = 2'b00; rsp_ready = 2'b00;
      step(); chk("bp_grant0", req_ready, 2'b01); adv();
      for (int k = 0; k < 2; k++) begin
         drive_rand();
         req_valid = 2'b10; req_lock = 2'b00; rsp_ready = 2'b00;
         step(); chk("bp_blocked", req_ready, 2'b00); adv();
      end
      drive_rand();
      req_valid = 2'b10; req_lock = 2'b00; rsp_ready = 2'b01;
      step(); chk("bp_drain_grant", req_ready, 2'b10); adv();
      req_valid = 2'b00; rsp_ready = 2'b11;
      step(); chk("bp_rsp", rsp_valid, 2'b10);
`ifdef ALU_ARB_PERF_EN
      chk("perf_s2", perf_stalls, 32'd2);
`endif
      adv();

      // Lock: req1 keeps the ALU for three locked ops plus the release.
      drive_rand();
      req_valid = 2'b01; req_lock = 2'b00; rsp_ready = 2'b11;
      step(); adv();
      for (int k = 0; k < 4; k++) begin
         drive_rand();
         req_valid = 2'b11; rsp_ready = 2'b11;
         req_lock = (k < 3) ? 2'b10 : 2'b00;
         step();
         chk("lock_owner", req_ready, 2'b10);
         adv();
      end
      drive_rand();
      req_valid = 2'b11; req_lock = 2'b00; rsp_ready = 2'b11;
      step(); chk("lock_after_release", req_ready, 2'b01); adv();
      req_valid = 2'b00;
      step(); adv();

      // Async reset with a pending response and lock held.
      drive_rand();
      req_valid = 2'b01; req_lock = 2'b01; rsp_ready = 2'b00;
      step(); adv();
      req_valid = 2'b11;
      chk("pre_rst_rsp", rsp_valid, 2'b01);
      chk("pre_rst_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_rsp", rsp_valid, 2'b00);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ready", req_ready, 2'b00);
      model_reset();
      req_valid = 2'b00;
      @(negedge clk);
      #1 rst_n = 1'b1;
      adv();
      drive_rand();
      req_valid = 2'b11; req_lock = 2'b00; rsp_ready = 2'b11;
      step(); chk("post_rst_rr0", req_ready, 2'b01); adv();

      // Randomized run against the model.
      for (int c = 0; c < 3000; c++) begin
         drive_rand();
         step();
         adv();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between NREQ requesters, e.g. the integer issue slot and the branch/address-generation unit.
- Each requester presents a full ALU operation (opc, imm, cond_true, op1, op2) under a valid/ready handshake.
- Grants are round-robin. The granted operation drives the shared ALU. Its result and compare flags are captured in a single response register and returned to the owner.
- An optional lock lets a requester hold the ALU across back-to-back operations.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, $clog2(NREQ) (min 1), width of the owner index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  NREQ  per-requester operation valid.
- req_ready  output  NREQ  per-requester accept; high only for the granted requester.
- req_lock  input  NREQ  keep ownership after this operation.
- req_opc  input  6*NREQ  opcode; slice i is [6i+5:6i].
- req_imm  input  NREQ  immediate-form flag.
- req_cond  input  NREQ  cond_true for select ops.
- req_op1  input  32*NREQ  operand 1.
- req_op2  input  32*NREQ  operand 2.
- alu_opc  output  6  to ALU.
- alu_imm  output  1  to ALU.
- alu_cond  output  1  to ALU.
- alu_op1  output  32  to ALU.
- alu_op2  output  32  to ALU.
- alu_res  input  32  from ALU.
- alu_cmp  input  2  from ALU.
- rsp_valid  output  NREQ  one-hot: result valid for requester i.
- rsp_ready  input  NREQ  requester consumes its response.
- rsp_res  output  32  registered result.
- rsp_cmp  output  2  registered compare flags.
- busy  output  1  response register occupied or lock held.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_res=0, rsp_cmp=0.
  - Round-robin pointer rr=0.
  - FSM=OPEN, lock owner=0, busy=0.
  - req_ready is 0 while in reset.
- Response slot:
  - The slot is free when rsp_valid==0, or when rsp_valid[o] & rsp_ready[o] this cycle (drain and refill in the same cycle is allowed).
  - No new grant while the slot is occupied and not draining.
- Arbitration, FSM OPEN:
  - Among req_valid, pick the first index at or after rr, with wrap-around.
  - If the slot is free, assert req_ready for that index only. The ALU inputs are driven from it combinationally.
  - On the handshake, capture alu_res/alu_cmp into rsp_res/rsp_cmp and set rsp_valid to one-hot of the index. rr becomes index+1 mod NREQ.
  - If req_lock is high at the handshake, go to LOCKED with owner=index.
- FSM LOCKED:
  - Only the owner may be granted; other requesters see req_ready=0.
  - A handshake with req_lock=0 returns the FSM to OPEN.
  - rr is not advanced while LOCKED, except on the releasing handshake, which advances rr to owner+1.
- When no grant occurs, the ALU inputs are driven from requester rr; the data is don't-care but the mux must stay stable.
- Latency:
  - Accept-to-response is 1 cycle: rsp_valid rises on the edge that completes the handshake.
  - Sustained throughput is 1 op/cycle when responses are consumed immediately.
- Response hold: rsp_res, rsp_cmp and rsp_valid hold unchanged until drained. Clearing on drain without refill: rsp_valid←0; data retains its last value.
- Boundary conditions:
  - A single requester is granted regardless of rr.
  - Simultaneous requests are served in rotation.
  - req_valid dropped without a handshake is legal and causes no state change.
  - A lock asserted on a non-granted cycle has no effect.
  - The owner may idle in LOCKED indefinitely; software/upper logic guarantees release.
- Reset mid-operation (rst_n low with a pending response or lock held): the pending response is discarded and the lock is cleared.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- When defined, add outputs perf_grants (32) and perf_stalls (32), both reset to 0:
  - perf_grants increments on every handshake.
  - perf_stalls increments every cycle in which any req_valid is high and no handshake occurs.
  - Both counters wrap at 2^32.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- NREQ=2; req0 valid only, opc=0, op1=5, op2=3 -> req_ready[0]=1; the next cycle rsp_valid=2'b01, rsp_res=8; rsp_cmp EQ=0.
- Both valid every cycle, rsp_ready=2'b11, rr=0 -> grants alternate 0,1,0,1; rsp_valid alternates 01,10; one response per cycle.
- rsp_ready[0]=0 after a grant to req0, req1 valid -> req_ready=00 until rsp_ready[0]=1; in that drain cycle req1 is granted and rsp_valid becomes 10 the next cycle.
- req1 granted with req_lock=1 for 3 ops, req0 valid throughout -> req0 blocked; the 4th req1 op has lock=0 and releases; the next grant goes to req0.
- rst_n pulsed low asynchronously while rsp_valid=01 and LOCKED -> rsp_valid=0 and busy=0 immediately; after release, round-robin starts at index 0.
- ALU_ARB_PERF_EN: 4 handshakes plus 2 stalled cycles -> perf_grants=4, perf_stalls=2.
